lp805x_tickgen: RTL and testbench

//  Schedule consumer on the receiving side of lp805x_schedfs.

---
 rtl/lp805x_tickgen_pkg.sv | 15 +
 rtl/lp805x_tickgen_cnt.sv | 32 +++
 rtl/lp805x_tickgen.sv | 121 ++++++++++++
 tb/tb_lp805x_tickgen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lp805x_tickgen_pkg.sv
// Shared types and defaults for the lp805x tick generator.
// The state encoding matches the one lp805x_schedfs uses.
package lp805x_tickgen_pkg;

  localparam int TICKGEN_FW    = 9;
  localparam int TICKGEN_IW    = 3;
  localparam int TICKGEN_TICKS = 4;

  typedef enum logic [1:0] {
    TICKGEN_IDLE = 2'd0,
    TICKGEN_RUN  = 2'd1,
    TICKGEN_DONE = 2'd2
  } tickgen_state_e;

endpackage

// File: rtl/lp805x_tickgen_cnt.sv
// FW-bit loadable down counter with clock-enable and zero flag.
// Load wins over decrement; the count parks at zero instead of wrapping.
module lp805x_tickgen_cnt #(
  parameter int FW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [FW-1:0] load_val,
  output logic [FW-1:0] cnt,
  output logic          zero
);

  localparam logic [FW-1:0] ONE = FW'(1);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (load)
        cnt <= load_val;
      else if (!zero)
        cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lp805x_tickgen.sv
// Tick generator: on a schedule request, strobes one of 2**IW channels every
// 'factor' clocks, TICKS times, then pulses done. All outputs are registered.
module lp805x_tickgen
  import lp805x_tickgen_pkg::*;
#(
  parameter int FW    = TICKGEN_FW,
  parameter int IW    = TICKGEN_IW,
  parameter int TICKS = TICKGEN_TICKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic [FW-1:0]     factor,
  input  logic [IW-1:0]     index,
  output logic [2**IW-1:0]  tick,
  output logic              busy,
  output logic              done,
  output logic [7:0]        count
);

  localparam int            NCH = 2**IW;
  localparam logic [FW-1:0] ONE = FW'(1);

  tickgen_state_e state, state_n;
  logic [FW-1:0]  f, f_n;
  logic [IW-1:0]  ch, ch_n;
  logic [7:0]     count_n;
  logic [NCH-1:0] tick_n;
  logic           busy_n, done_n;

  logic           cnt_en, cnt_load, cnt_zero;
  logic [FW-1:0]  load_val, cnt;

  lp805x_tickgen_cnt #(.FW(FW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    f_n      = f;
    ch_n     = ch;
    count_n  = count;
    tick_n   = tick;
    busy_n   = busy;
    done_n   = done;
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    load_val = f - ONE;

    if (enable) begin
      tick_n = '0;
      done_n = 1'b0;
      if (start) begin
        // A request overrides whatever schedule is in flight.
        if (factor == '0) begin
          state_n = TICKGEN_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n  = TICKGEN_RUN;
          f_n      = factor;
          ch_n     = index;
          count_n  = '0;
          busy_n   = 1'b1;
          cnt_en   = 1'b1;
          cnt_load = 1'b1;
          load_val = factor - ONE;
        end
      end else begin
        unique case (state)
          TICKGEN_RUN: begin
            cnt_en = 1'b1;
            if (cnt_zero) begin
              tick_n[ch] = 1'b1;
              count_n    = count + 8'd1;
              cnt_load   = 1'b1;
              if (count_n == 8'(TICKS))
                state_n = TICKGEN_DONE;
            end
          end
          TICKGEN_DONE: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = TICKGEN_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TICKGEN_IDLE;
      f     <= '0;
      ch    <= '0;
      count <= '0;
      tick  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      f     <= f_n;
      ch    <= ch_n;
      count <= count_n;
      tick  <= tick_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_lp805x_tickgen.sv
// Scoreboard bench for lp805x_tickgen: stimulus queues expected tick/done
// events tagged with their cycle; a negedge monitor pops and compares them.
module tb_lp805x_tickgen;

  logic       clk = 1'b0;
  logic       rst, enable, start;
  logic [8:0] factor;
  logic [2:0] index;
  logic [7:0] tick;
  logic       busy, done;
  logic [7:0] count;

  lp805x_tickgen dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .start  (start),
    .factor (factor),
    .index  (index),
    .tick   (tick),
    .busy   (busy),
    .done   (done),
    .count  (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] tick;
    logic       done;
    logic [7:0] count;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] last_count = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any strobe or done must match the oldest expected event.
  always @(negedge clk) begin
    if ((|tick) === 1'b1 || done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {23'd0, done, tick}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_tick", tick, e.tick);
        check("ev_done", done, e.done);
        check("ev_count", count, e.count);
      end
    end
  end

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one request; n is the edge that samples it.
  task automatic issue(input int f, input int idx, input int shift, input bit abort,
                       output int n);
    ev_t e;
    if (abort) exp_q.delete();
    start  = 1'b1;
    factor = 9'(f);
    index  = 3'(idx);
    n      = cyc + 1;
    if (f == 0) begin
      e.cyc = n; e.tick = 8'd0; e.done = 1'b1; e.count = last_count;
      exp_q.push_back(e);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        e.cyc = n + k * f + shift; e.tick = 8'(1 << idx); e.done = 1'b0; e.count = 8'(k);
        exp_q.push_back(e);
      end
      e.cyc = n + 4 * f + 1 + shift; e.tick = 8'd0; e.done = 1'b1; e.count = 8'd4;
      exp_q.push_back(e);
      last_count = 8'd4;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    factor = 9'h1ab;
    index  = 3'(idx + 3);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tick"}, tick, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_done"}, done, 32'd0);
    check({tag, "_count"}, count, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, n1;
    rst = 1'b1; enable = 1'b1; start = 1'b1; factor = 9'd5; index = 3'd2;

    // 1: reset held with start high
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_idle("reset");
    end
    rst = 1'b0; start = 1'b0;

    // 2: factor 5, channel 2
    issue(5, 2, 0, 1'b0, n);
    step_to(n + 20);
    check("t2_busy_last_tick", busy, 32'd1);
    step_to(n + 21);
    check("t2_busy_at_done", busy, 32'd0);
    check("t2_done", done, 32'd1);
    step_to(n + 24);
    check("t2_queue_empty", exp_q.size(), 32'd0);

    // 3: factor 1, channel 7
    issue(1, 7, 0, 1'b0, n);
    check("t3_busy", busy, 32'd1);
    check("t3_count_start", count, 32'd0);
    step_to(n + 8);
    check("t3_queue_empty", exp_q.size(), 32'd0);

    // 4: zero factor
    issue(0, 5, 0, 1'b0, n);
    check("t4_busy", busy, 32'd0);
    step_to(n + 5);
    check("t4_busy_later", busy, 32'd0);
    check("t4_queue_empty", exp_q.size(), 32'd0);

    // 5: factor 8 with enable low for 3 edges mid-period
    issue(8, 4, 3, 1'b0, n);
    step_to(n + 2);
    enable = 1'b0;
    start  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t5_frozen_tick", tick, 32'd0);
      check("t5_frozen_busy", busy, 32'd1);
      check("t5_frozen_count", count, 32'd0);
      check("t5_frozen_done", done, 32'd0);
    end
    start  = 1'b0;
    enable = 1'b1;
    step_to(n + 38);
    check("t5_queue_empty", exp_q.size(), 32'd0);

    // 6: restart mid-run, then reset mid-run
    issue(30, 1, 0, 1'b0, n1);
    step_to(n1 + 10);
    issue(501, 0, 0, 1'b1, n);
    check("t6_count_restart", count, 32'd0);
    step_to(n + 503);
    check("t6_count_one", count, 32'd1);
    check("t6_busy", busy, 32'd1);
    rst = 1'b1;
    start = 1'b1;
    factor = 9'd3;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_idle("t6_reset");
    rst = 1'b0;
    start = 1'b0;
    step_to(cyc + 6);
    check_idle("t6_after_reset");
    check("t6_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
